// File: rtl/serial_duplex_ctrl_pkg.sv
// ============================================================================
// Module : serial_duplex_ctrl_pkg
// Brief  : Shared command/mode encodings and controller state enum.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_duplex_ctrl_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;

    localparam logic [1:0] MODE_DUPLEX  = 2'b00;
    localparam logic [1:0] MODE_TX_ONLY = 2'b01;
    localparam logic [1:0] MODE_RX_ONLY = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic tx_enabled(input logic [1:0] mode);
        return (mode == MODE_DUPLEX) || (mode == MODE_TX_ONLY);
    endfunction

    function automatic logic rx_enabled(input logic [1:0] mode);
        return (mode == MODE_DUPLEX) || (mode == MODE_RX_ONLY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_duplex_ctrl_xfer_timeout.sv
// ============================================================================
// Module : xfer_timeout
// Brief  : Transfer watchdog; expired flags the TIMEOUT_CYCLES-th enabled cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xfer_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_duplex_ctrl.sv
// ============================================================================
// Module : serial_duplex_ctrl
// Brief  : Host request -> tx/rx command sequencing with timeout and response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_duplex_ctrl
    import serial_duplex_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int START_HOLD     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_mode,
    output logic [1:0]  tx_state,
    output logic [31:0] tx_word,
    input  logic        tx_finish,
    output logic [1:0]  rx_state,
    input  logic [31:0] rx_word,
    input  logic        rx_finish,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int c_HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

    state_e              state_q, state_d;
    logic [c_HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]          mode_q, mode_d;
    logic [31:0]         tx_word_q, tx_word_d;
    logic [31:0]         rx_word_q, rx_word_d;
    logic                tx_done_q, tx_done_d;
    logic                rx_done_q, rx_done_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic w_tmo_clear;
    logic w_tmo_en;
    logic w_expired;
    logic w_all_done;
    logic [31:0] w_rx_data;

    xfer_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (w_tmo_clear),
        .enable_i  (w_tmo_en),
        .expired_o (w_expired)
    );

    // A finish pulse in the current cycle counts toward completion so the
    // response follows the last pulse by exactly one cycle.
    assign w_all_done = (!tx_enabled(mode_q) || tx_done_q || tx_finish) &&
                        (!rx_enabled(mode_q) || rx_done_q || rx_finish);
    assign w_rx_data  = rx_finish ? rx_word : rx_word_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        mode_d      = mode_q;
        tx_word_d   = tx_word_q;
        rx_word_d   = rx_word_q;
        tx_done_d   = tx_done_q;
        rx_done_d   = rx_done_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        w_tmo_clear = 1'b0;
        w_tmo_en    = 1'b0;

        if (state_q == ST_START || state_q == ST_WAIT) begin
            w_tmo_en  = 1'b1;
            tx_done_d = tx_done_q | tx_finish;
            rx_done_d = rx_done_q | rx_finish;
            rx_word_d = w_rx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    tx_word_d   = req_data;
                    mode_d      = req_mode;
                    tx_done_d   = 1'b0;
                    rx_done_d   = 1'b0;
                    rx_word_d   = '0;
                    hold_d      = '0;
                    w_tmo_clear = 1'b1;
                    if (req_mode == MODE_RSVD) begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                hold_d = hold_q + c_HOLD_W'(1);
                if (w_expired) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else if (hold_q == c_HOLD_W'(START_HOLD - 1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_all_done) begin
                    state_d    = ST_RESP;
                    rsp_data_d = rx_enabled(mode_q) ? w_rx_data : 32'd0;
                    rsp_err_d  = 1'b0;
                end else if (w_expired) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            mode_q     <= MODE_DUPLEX;
            tx_word_q  <= '0;
            rx_word_q  <= '0;
            tx_done_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            mode_q     <= mode_d;
            tx_word_q  <= tx_word_d;
            rx_word_q  <= rx_word_d;
            tx_done_q  <= tx_done_d;
            rx_done_q  <= rx_done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign tx_word   = tx_word_q;
    assign tx_state  = (state_q == ST_START && tx_enabled(mode_q)) ? CMD_START : CMD_IDLE;
    assign rx_state  = (state_q == ST_START && rx_enabled(mode_q)) ? CMD_START : CMD_IDLE;

endmodule

`default_nettype wire

// File: tb/tb_serial_duplex_ctrl.sv
// ============================================================================
// Module : tb_serial_duplex_ctrl
// Brief  : Self-checking bench with a cycle-count reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_duplex_ctrl;

    localparam int T = 16;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_data = '0;
    logic [1:0]  req_mode = '0;
    logic [1:0]  tx_state;
    logic [31:0] tx_word;
    logic        tx_finish = 1'b0;
    logic [1:0]  rx_state;
    logic [31:0] rx_word = '0;
    logic        rx_finish = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    serial_duplex_ctrl #(
        .TIMEOUT_CYCLES (T),
        .START_HOLD     (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_mode  (req_mode),
        .tx_state  (tx_state),
        .tx_word   (tx_word),
        .tx_finish (tx_finish),
        .rx_state  (rx_state),
        .rx_word   (rx_word),
        .rx_finish (rx_finish),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle 0 carries the request; cycles 1..n are START/WAIT; rsp_valid in n+1.
    // txk/rxk: cycle index of the finish pulse, 0 = never.
    function automatic void model(input logic [1:0] mode, input int txk, input int rxk,
                                  input logic [31:0] rxw, output int n,
                                  output logic err, output logic [31:0] data);
        bit tx_en = (mode == 2'b00) || (mode == 2'b01);
        bit rx_en = (mode == 2'b00) || (mode == 2'b10);
        bit ok = 1;
        int last = 0;
        if (mode == 2'b11) begin
            n = 0; err = 1'b1; data = '0;
            return;
        end
        if (tx_en) begin
            if (txk == 0) ok = 0; else if (txk > last) last = txk;
        end
        if (rx_en) begin
            if (rxk == 0) ok = 0; else if (rxk > last) last = rxk;
        end
        if (last < H + 1) last = H + 1;
        if (ok && last <= T) begin
            n = last; err = 1'b0; data = rx_en ? rxw : 32'd0;
        end else begin
            n = T; err = 1'b1; data = '0;
        end
    endfunction

    task automatic run_xact(input logic [1:0] mode, input logic [31:0] d, input int txk,
                            input int rxk, input logic [31:0] rxw, input int hold);
        int n;
        logic err;
        logic [31:0] ed;
        logic [1:0] etx, erx;
        bit tx_en = (mode == 2'b00) || (mode == 2'b01);
        bit rx_en = (mode == 2'b00) || (mode == 2'b10);
        model(mode, txk, rxk, rxw, n, err, ed);

        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_req: req_ready=%b busy=%b want 1/0", req_ready, busy);
        end
        req_valid = 1'b1; req_data = d; req_mode = mode;
        step();
        req_valid = 1'b0; req_data = $urandom; req_mode = 2'($urandom);

        for (int c = 1; c <= n + 1; c++) begin
            etx = (tx_en && c <= H && mode != 2'b11) ? 2'd1 : 2'd0;
            erx = (rx_en && c <= H && mode != 2'b11) ? 2'd1 : 2'd0;
            checks++;
            if (tx_state !== etx || rx_state !== erx) begin
                errors++;
                $display("FAIL cmd_state c=%0d: tx=%0d rx=%0d want %0d/%0d", c, tx_state, rx_state, etx, erx);
            end
            checks++;
            if (rsp_valid !== (c == n + 1) || busy !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL handshake c=%0d: rsp_valid=%b busy=%b req_ready=%b want %b/1/0",
                         c, rsp_valid, busy, req_ready, (c == n + 1));
            end
            if (c == 1) begin
                checks++;
                if (tx_word !== d) begin
                    errors++;
                    $display("FAIL tx_word: got %h want %h", tx_word, d);
                end
            end
            if (c <= n) begin
                tx_finish = (c == txk);
                rx_finish = (c == rxk);
                rx_word   = (c == rxk) ? rxw : $urandom;
                rsp_ready = 1'($urandom);
                step();
            end
        end
        rsp_ready = 1'b0;
        checks++;
        if (rsp_data !== ed || rsp_err !== err) begin
            errors++;
            $display("FAIL response: data=%h err=%b want %h/%b", rsp_data, rsp_err, ed, err);
        end
        for (int i = 0; i < hold; i++) begin
            tx_finish = 1'($urandom);
            rx_finish = 1'($urandom);
            rx_word   = $urandom;
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_err !== err || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: valid=%b data=%h err=%b ready=%b want 1/%h/%b/0",
                         rsp_valid, rsp_data, rsp_err, req_ready, ed, err);
            end
        end
        tx_finish = 1'b0; rx_finish = 1'b0; rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: valid=%b ready=%b busy=%b want 0/1/0", rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (tx_state !== 2'd0 || rx_state !== 2'd0 || tx_word !== 32'd0 || rsp_valid !== 1'b0 ||
            rsp_data !== 32'd0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%0d rx=%0d word=%h valid=%b data=%h err=%b busy=%b want all 0",
                     tx_state, rx_state, tx_word, rsp_valid, rsp_data, rsp_err, busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_duplex();
        while (cyc < 30) step();
        run_xact(2'b00, 32'h56D01953, 10, 15, 32'h56D01953, 0);
        run_xact(2'b00, 32'hA5A5_0001, 1, 2, 32'h1234_5678, 0);
    endtask

    task automatic test_tx_only();
        run_xact(2'b01, 32'hCAFE_F00D, 7, 0, 32'h0, 0);
        run_xact(2'b01, 32'h0BAD_BEEF, 3, 5, 32'hFFFF_0000, 1);
    endtask

    task automatic test_timeout();
        run_xact(2'b10, 32'h1111_2222, 0, 0, 32'h0, 0);
        run_xact(2'b10, 32'h3333_4444, 0, T, 32'h9876_5432, 0);
        run_xact(2'b10, 32'h5555_6666, 0, T + 1, 32'h9876_5432, 0);
        run_xact(2'b00, 32'h7777_8888, 4, 0, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        run_xact(2'b00, 32'hDEAD_0005, 6, 9, 32'h0F0F_F0F0, 5);
    endtask

    task automatic test_reserved();
        run_xact(2'b11, 32'h2468_ACE0, 0, 0, 32'h0, 0);
        run_xact(2'b11, 32'h1357_9BDF, 1, 1, 32'hFFFF_FFFF, 2);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_data = 32'hFEED_1234; req_mode = 2'b10;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (tx_state !== 2'd0 || rx_state !== 2'd0 || tx_word !== 32'd0 || rsp_valid !== 1'b0 ||
            rsp_data !== 32'd0 || rsp_err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: tx=%0d rx=%0d word=%h valid=%b data=%h err=%b busy=%b ready=%b want 0s, ready=1",
                     tx_state, rx_state, tx_word, rsp_valid, rsp_data, rsp_err, busy, req_ready);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < T + 6; i++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet i=%0d: valid=%b busy=%b want 0/0", i, rsp_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_xact(2'($urandom), $urandom, int'($urandom_range(0, 20)),
                     int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            run_xact(2'($urandom_range(0, 2)), $urandom, int'($urandom_range(1, 6)),
                     int'($urandom_range(1, 6)), $urandom, 0);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_duplex();
        test_tx_only();
        test_timeout();
        test_backpressure();
        test_reserved();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_duplex_ctrl.md
SERIAL_DUPLEX_CTRL -- requirements
Module: serial_duplex_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, max cycles from command issue to completion before error.
REQ-002 SHALL have parameter START_HOLD, default 2, cycles the start command is held on a channel.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: host request handshake.
REQ-006 SHALL have ports req_data in 32, word to transmit; req_mode in 2: 00 duplex, 01 tx-only, 10 rx-only, 11 reserved.
REQ-007 SHALL have ports tx_state out 2, tx_word out 32, tx_finish in 1: command, data and done pulse of the transmit FSM.
REQ-008 SHALL have ports rx_state out 2, rx_word in 32, rx_finish in 1: command, received data and done pulse of the receive FSM.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 32, rsp_err out 1: response handshake.
REQ-010 SHALL have port busy out 1, high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, START, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-012 In IDLE, req_valid&&req_ready SHALL capture req_data into tx_word and req_mode, then enter START next cycle (mode 11: enter RESP directly).
REQ-013 In START, each enabled channel's state output SHALL be CMD_START (2'd1) for exactly START_HOLD cycles, then CMD_IDLE (2'd0); disabled channels stay CMD_IDLE.
REQ-014 After START_HOLD cycles SHALL move to WAIT.
REQ-015 Sticky done flags SHALL capture tx_finish/rx_finish in START and WAIT; finish pulses in IDLE/RESP SHALL be ignored.
REQ-016 rx_word SHALL be captured on the cycle rx_finish is sampled high in START/WAIT.
REQ-017 When all enabled channels are done, SHALL enter RESP next cycle with rsp_err=0, rsp_data=captured rx word (0 for tx-only).
REQ-018 A timeout counter SHALL clear on entering START, count each START/WAIT cycle, and at TIMEOUT_CYCLES force RESP with rsp_err=1, rsp_data=0.
REQ-019 Completion and timeout in the same cycle: completion SHALL win.
REQ-020 Mode 11 SHALL produce RESP with rsp_err=1, rsp_data=0, no command issued.
REQ-021 rsp_valid SHALL be 1 only in RESP, rsp_data/rsp_err stable while rsp_valid&&!rsp_ready; rsp_ready high SHALL return to IDLE next cycle.
REQ-022 Minimum request-to-rsp_valid latency SHALL be START_HOLD+2 cycles.

Reset
REQ-023 rst low SHALL asynchronously force IDLE; req_ready=1 after release; tx_state=rx_state=0, tx_word=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, counters and done flags cleared.
REQ-024 Reset mid-transfer SHALL abandon it without emitting a response.

Structure
REQ-025 CMD_IDLE/CMD_START encodings, mode encodings and state enum SHALL reside in a shared package used also by the tx/rx FSMs.
REQ-026 Timeout counter SHALL be a sub-module xfer_timeout (clear, enable, expired).

Verification
REQ-027 Duplex: req_data=32'h56D01953, mode 00, tx_finish at cycle 40, rx_finish at 45 with rx_word=32'h56D01953 -> rsp_valid next cycle, rsp_data=32'h56D01953, rsp_err=0.
REQ-028 Tx-only: mode 01, tx_finish only -> rsp_data=0, rsp_err=0; rx_state stays 0 throughout.
REQ-029 Timeout: mode 10, no rx_finish, TIMEOUT_CYCLES=16 -> rsp_err=1 after 16 cycles in START/WAIT.
REQ-030 Backpressure: rsp_ready low 5 cycles -> rsp_valid/data held, req_ready=0 until accept.
REQ-031 Mode 11 -> rsp_err=1 one cycle after accept; tx_state/rx_state never 1.
REQ-032 Reset asserted in WAIT -> all outputs at reset values immediately; no rsp_valid after release.
